// File: rtl/link_up_pkg.sv
// rtl/link_up_pkg.sv - shared types and sizing helpers for the link upstream credit serdes
//
// Purpose : state encoding, width helpers and the credit lane type used by
//           link_ddr_upstream_credit_serdes and link_up_credit_ctr.
// Ports   : none (package).
package link_up_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,   // no word held
      SEND = 1'b1    // word held, beats outstanding
   } state_t;

   localparam int DEF_MAX_CREDITS = 16;

   // Core word width: every channel contributes CH_W bits on each of RATIO beats.
   function automatic int link_width(input int ch_w, input int num_ch, input int ratio);
      return ch_w * num_ch * ratio;
   endfunction

   // Credit lane width; must represent MAX_CREDITS itself, hence the +1.
   function automatic int credit_width(input int max_credits);
      return $clog2(max_credits + 1);
   endfunction

   typedef logic [credit_width(DEF_MAX_CREDITS)-1:0] credit_t;

endpackage

// File: rtl/link_up_credit_ctr.sv
// rtl/link_up_credit_ctr.sv - per-channel saturating credit counter
//
// Purpose : holds the credits for one channel; a beat consumes one, a token
//           pulse returns TOKEN_BATCH. Saturates at MAX_CREDITS.
// Ports   : clk, rst         clock, synchronous active-high reset
//           dec              a beat fired this cycle (only when has_credit)
//           inc              token pulse from the downstream
//           credits          current credit count (MAX_CREDITS after reset)
//           has_credit       credits >= 1
//           overflow         this cycle's update exceeded MAX_CREDITS
module link_up_credit_ctr
   import link_up_pkg::*;
#(
   parameter int MAX_CREDITS = 16,
   parameter int TOKEN_BATCH = 4,
   parameter int CRW         = credit_width(MAX_CREDITS)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           dec,
   input  logic           inc,
   output logic [CRW-1:0] credits,
   output logic           has_credit,
   output logic           overflow
);

   // One extra bit: MAX_CREDITS + TOKEN_BATCH <= 2*MAX_CREDITS fits in CRW+1 bits.
   localparam logic [CRW:0] MAX_X   = (CRW+1)'(MAX_CREDITS);
   localparam logic [CRW:0] BATCH_X = (CRW+1)'(TOKEN_BATCH);

   logic [CRW:0] sum;

   // dec is only asserted with credits >= 1, so the subtraction never wraps.
   always_comb begin
      sum = {1'b0, credits} - {{CRW{1'b0}}, dec} + (inc ? BATCH_X : '0);
   end

   assign overflow   = (sum > MAX_X);
   assign has_credit = |credits;

   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CRW'(MAX_CREDITS);
      end else if (overflow) begin
         credits <= CRW'(MAX_CREDITS);
      end else begin
         credits <= sum[CRW-1:0];
      end
   end

endmodule

// File: rtl/link_ddr_upstream_credit_serdes.sv
// rtl/link_ddr_upstream_credit_serdes.sv - credit-gated wide-word to multi-channel beat serialiser
//
// Purpose : holds one core word and sends it as RATIO beats over NUM_CH
//           channels in lockstep, gated by per-channel credits.
//           Optional statistics counters under macro LINK_UP_STATS_EN.
// Ports   : clk, rst                   clock, synchronous active-high reset
//           core_valid_i/core_data_i   core word handshake input
//           core_ready_o               word accepted this cycle when valid
//           token_i                    per-channel credit return pulses
//           io_valid_o/io_data_o       registered beat per channel
//           credit_o                   credits per channel, CRW bits per lane
//           busy_o                     a held word still has beats to send
//           err_o                      sticky credit overflow
//           sent_cnt_o                 words fully sent (stats)
//           returned_cnt_o             credits returned on channel 0 (stats)
module link_ddr_upstream_credit_serdes
   import link_up_pkg::*;
#(
   parameter int CH_W        = 8,
   parameter int NUM_CH      = 2,
   parameter int RATIO       = 4,
   parameter int MAX_CREDITS = 16,
   parameter int TOKEN_BATCH = 4,
   parameter int CNT_W       = 7
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         core_valid_i,
   input  logic [link_width(CH_W, NUM_CH, RATIO)-1:0]   core_data_i,
   output logic                                         core_ready_o,
   input  logic [NUM_CH-1:0]                            token_i,
   output logic [NUM_CH-1:0]                            io_valid_o,
   output logic [NUM_CH*CH_W-1:0]                       io_data_o,
   output logic [NUM_CH*credit_width(MAX_CREDITS)-1:0]  credit_o,
   output logic                                         busy_o,
   output logic                                         err_o,
   output logic [CNT_W-1:0]                             sent_cnt_o,
   output logic [CNT_W-1:0]                             returned_cnt_o
);

   localparam int CRW    = credit_width(MAX_CREDITS);
   localparam int BEAT_W = NUM_CH * CH_W;
   localparam int KW     = $clog2(RATIO);
   localparam logic [KW-1:0] K_LAST = KW'(RATIO - 1);

   state_t                        state;
   logic                          hold_valid;
   logic [RATIO-1:0][BEAT_W-1:0]  hold_beats;   // beat k = channels 0..NUM_CH-1 of slice k
   logic [KW-1:0]                 k;
   logic [NUM_CH-1:0]             has_credit;
   logic [NUM_CH-1:0]             overflow;
   logic                          fire;
   logic                          last_fire;
   logic                          accept;

   assign hold_valid   = (state == SEND);
   assign fire         = hold_valid & (&has_credit);
   assign last_fire    = fire & (k == K_LAST);
   // Accepting on the last beat lets consecutive words stream without a bubble.
   assign core_ready_o = ~hold_valid | last_fire;
   assign accept       = core_valid_i & core_ready_o;
   assign busy_o       = hold_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         hold_beats <= '0;
         io_valid_o <= '0;
         io_data_o  <= '0;
         err_o      <= 1'b0;
      end else begin
         if (accept) begin
            state      <= SEND;
            hold_beats <= core_data_i;
            k          <= '0;
         end else if (last_fire) begin
            state <= IDLE;
            k     <= '0;
         end else if (fire) begin
            k <= k + KW'(1);
         end
         io_valid_o <= {NUM_CH{fire}};
         if (fire) begin
            io_data_o <= hold_beats[k];
         end
         if (|overflow) begin
            err_o <= 1'b1;
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      link_up_credit_ctr #(
         .MAX_CREDITS (MAX_CREDITS),
         .TOKEN_BATCH (TOKEN_BATCH),
         .CRW         (CRW)
      ) u_ctr (
         .clk        (clk),
         .rst        (rst),
         .dec        (fire),
         .inc        (token_i[c]),
         .credits    (credit_o[c*CRW +: CRW]),
         .has_credit (has_credit[c]),
         .overflow   (overflow[c])
      );
   end

`ifdef LINK_UP_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sent_cnt_o     <= '0;
         returned_cnt_o <= '0;
      end else begin
         if (last_fire) begin
            sent_cnt_o <= sent_cnt_o + CNT_W'(1);
         end
         if (token_i[0]) begin
            returned_cnt_o <= returned_cnt_o + CNT_W'(TOKEN_BATCH);
         end
      end
   end
`else
   assign sent_cnt_o     = '0;
   assign returned_cnt_o = '0;
`endif

endmodule

// File: tb/tb_link_ddr_upstream_credit_serdes.sv
// tb/tb_link_ddr_upstream_credit_serdes.sv - self-checking bench for link_ddr_upstream_credit_serdes
module tb_link_ddr_upstream_credit_serdes;

   localparam int RATIO = 4;
   localparam int MAXC  = 16;
   localparam int TB    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_valid = 1'b0;
   logic [63:0] core_data = '0;
   logic [1:0]  token = '0;
   logic        core_ready;
   logic [1:0]  io_valid;
   logic [15:0] io_data;
   logic [9:0]  credit;
   logic        busy;
   logic        err;
   logic [6:0]  sent_cnt;
   logic [6:0]  ret_cnt;

   always #5 clk = ~clk;

   link_ddr_upstream_credit_serdes #(
      .CH_W(8), .NUM_CH(2), .RATIO(RATIO), .MAX_CREDITS(MAXC), .TOKEN_BATCH(TB), .CNT_W(7)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .core_valid_i   (core_valid),
      .core_data_i    (core_data),
      .core_ready_o   (core_ready),
      .token_i        (token),
      .io_valid_o     (io_valid),
      .io_data_o      (io_data),
      .credit_o       (credit),
      .busy_o         (busy),
      .err_o          (err),
      .sent_cnt_o     (sent_cnt),
      .returned_cnt_o (ret_cnt)
   );

   int passed = 0;
   int total  = 0;

   // Reference model: one held word, integer credits, beat index.
   bit          m_hold;
   int          m_k;
   logic [63:0] m_word;
   int          m_cred[2];
   bit          m_err;
   int          m_sent;
   int          m_ret;
   logic [1:0]  e_v;
   logic [15:0] e_d;
   bit          m_acc;

   wire [44:0] dut_vec = {io_valid, io_data, credit, busy, err, core_ready, sent_cnt, ret_cnt};

   function automatic logic [44:0] exp_vec();
      bit rdy;
      logic [6:0] s;
      logic [6:0] r;
      rdy = !m_hold || (m_cred[0] >= 1 && m_cred[1] >= 1 && m_k == RATIO - 1);
      s = '0;
      r = '0;
`ifdef LINK_UP_STATS_EN
      s = 7'(m_sent);
      r = 7'(m_ret);
`endif
      return {e_v, e_d, 5'(m_cred[1]), 5'(m_cred[0]), m_hold, m_err, rdy, s, r};
   endfunction

   task automatic model_reset();
      m_hold = 0; m_k = 0; m_word = '0; m_cred[0] = MAXC; m_cred[1] = MAXC;
      m_err = 0; m_sent = 0; m_ret = 0; e_v = '0; e_d = '0; m_acc = 0;
   endtask

   // Advance one clock and update the model from the inputs applied this cycle.
   task automatic tick();
      bit fire;
      bit last;
      bit v;
      bit r;
      logic [63:0] d;
      logic [1:0]  t;
      v = core_valid; d = core_data; t = token; r = rst;
      fire  = m_hold && m_cred[0] > 0 && m_cred[1] > 0;
      last  = fire && m_k == RATIO - 1;
      m_acc = v && (!m_hold || last) && !r;
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
         return;
      end
      e_v = fire ? 2'b11 : 2'b00;
      if (fire) e_d = m_word[m_k*16 +: 16];
      for (int c = 0; c < 2; c++) begin
         int n;
         n = m_cred[c] - int'(fire) + (t[c] ? TB : 0);
         if (n > MAXC) begin
            n = MAXC;
            m_err = 1;
         end
         m_cred[c] = n;
      end
      if (last) m_sent = (m_sent + 1) % 128;
      if (t[0]) m_ret = (m_ret + TB) % 128;
      if (m_acc) begin
         m_hold = 1; m_k = 0; m_word = d;
      end else if (last) begin
         m_hold = 0; m_k = 0;
      end else if (fire) begin
         m_k++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; core_valid = 1'b0; token = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (dut_vec !== exp_vec()) $display("FAIL reset_vec: got %h expected %h", dut_vec, exp_vec());
      else passed++;
      total++;
      if ({credit, core_ready, io_valid, busy, err} !== {10'h210, 1'b1, 2'b00, 1'b0, 1'b0})
         $display("FAIL reset_values: got %h expected %h", {credit, core_ready, io_valid, busy, err},
                  {10'h210, 1'b1, 2'b00, 1'b0, 1'b0});
      else passed++;
   endtask

   task automatic test_single_word();
      logic [15:0] exp_b [4];
      exp_b[0] = 16'h0908; exp_b[1] = 16'h0B0A; exp_b[2] = 16'h0D0C; exp_b[3] = 16'h0F0E;
      core_data = 64'h0F0E0D0C0B0A0908; core_valid = 1'b1;
      tick();
      core_valid = 1'b0;
      total++;
      if (dut_vec !== exp_vec()) $display("FAIL single_accept: got %h expected %h", dut_vec, exp_vec());
      else passed++;
      for (int b = 0; b < 4; b++) begin
         tick();
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL single_vec beat %0d: got %h expected %h", b, dut_vec, exp_vec());
         else passed++;
         total++;
         if ({io_valid, io_data} !== {2'b11, exp_b[b]})
            $display("FAIL single_beat %0d: got %h expected %h", b, {io_valid, io_data}, {2'b11, exp_b[b]});
         else passed++;
      end
      total++;
      if ({busy, credit} !== {1'b0, 10'h18C}) $display("FAIL single_end: got %h expected %h", {busy, credit}, {1'b0, 10'h18C});
      else passed++;
      tick();
      total++;
      if (io_valid !== 2'b00) $display("FAIL single_idle: got %b expected 00", io_valid);
      else passed++;
   endtask

   task automatic test_exhaustion();
      logic [63:0] w [5];
      int idx;
      int beats;
      do_reset();
      for (int i = 0; i < 5; i++) w[i] = {$urandom, $urandom};
      idx = 0; beats = 0;
      core_valid = 1'b1; core_data = w[0];
      for (int i = 0; i < 20; i++) begin
         tick();
         if (io_valid === 2'b11) beats++;
         if (m_acc) idx++;
         if (idx < 5) core_data = w[idx];
         else core_valid = 1'b0;
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL exhaust_vec cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         else passed++;
      end
      core_valid = 1'b0;
      total++;
      if (beats !== 16) $display("FAIL exhaust_beats: got %0d expected 16", beats);
      else passed++;
      total++;
      if ({credit, core_ready, busy, io_valid} !== {10'h000, 1'b0, 1'b1, 2'b00})
         $display("FAIL exhaust_stall: got %h expected %h", {credit, core_ready, busy, io_valid}, {10'h000, 1'b0, 1'b1, 2'b00});
      else passed++;
      token = 2'b11;
      tick();
      token = 2'b00;
      total++;
      if (credit !== 10'h084) $display("FAIL exhaust_token: got %h expected 084", credit);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL exhaust_resume %0d: got %h expected %h", i, dut_vec, exp_vec());
         else passed++;
      end
      total++;
      if ({io_valid, io_data, busy, credit} !== {2'b11, w[4][63:48], 1'b0, 10'h000})
         $display("FAIL exhaust_last: got %h expected %h", {io_valid, io_data, busy, credit}, {2'b11, w[4][63:48], 1'b0, 10'h000});
      else passed++;
   endtask

   // Starts at credits 0/0 and leaves a held word at k=0 with credits 4/4.
   task automatic test_asymmetric();
      core_data = {$urandom, $urandom}; core_valid = 1'b1;
      tick();
      core_valid = 1'b0;
      tick();
      total++;
      if (dut_vec !== exp_vec()) $display("FAIL asym_hold: got %h expected %h", dut_vec, exp_vec());
      else passed++;
      token = 2'b01;
      tick();
      token = 2'b00;
      total++;
      if ({credit, io_valid, busy} !== {10'h004, 2'b00, 1'b1})
         $display("FAIL asym_ch0: got %h expected %h", {credit, io_valid, busy}, {10'h004, 2'b00, 1'b1});
      else passed++;
      tick();
      total++;
      if ({io_valid, core_ready} !== {2'b00, 1'b0}) $display("FAIL asym_stall: got %h expected 0", {io_valid, core_ready});
      else passed++;
      token = 2'b10;
      tick();
      token = 2'b00;
      total++;
      if (dut_vec !== exp_vec() || credit !== 10'h084)
         $display("FAIL asym_ch1: got %h expected %h", dut_vec, exp_vec());
      else passed++;
   endtask

   task automatic test_simul_token_fire();
      logic [15:0] b0;
      b0 = m_word[15:0];
      token = 2'b11;
      tick();
      token = 2'b00;
      total++;
      if ({io_valid, io_data, credit} !== {2'b11, b0, 10'h0E7})
         $display("FAIL simul: got %h expected %h", {io_valid, io_data, credit}, {2'b11, b0, 10'h0E7});
      else passed++;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL simul_drain %0d: got %h expected %h", i, dut_vec, exp_vec());
         else passed++;
      end
   endtask

   task automatic test_overflow();
      do_reset();
      token = 2'b10;
      tick();
      token = 2'b00;
      total++;
      if ({credit, err} !== {10'h210, 1'b1} || dut_vec !== exp_vec())
         $display("FAIL overflow: got %h expected %h", dut_vec, exp_vec());
      else passed++;
      for (int i = 0; i < 3; i++) tick();
      total++;
      if (err !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", err);
      else passed++;
      do_reset();
      total++;
      if (err !== 1'b0) $display("FAIL overflow_clear: got %b expected 0", err);
      else passed++;
   endtask

   task automatic test_reset_mid_word();
      logic [63:0] w;
      logic [63:0] w2;
      w = {$urandom, $urandom}; w2 = {$urandom, $urandom};
      core_data = w; core_valid = 1'b1;
      tick();
      core_valid = 1'b0;
      tick();
      tick();
      total++;
      if ({io_valid, io_data} !== {2'b11, w[31:16]})
         $display("FAIL mid_beat1: got %h expected %h", {io_valid, io_data}, {2'b11, w[31:16]});
      else passed++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({io_valid, credit, core_ready, busy} !== {2'b00, 10'h210, 1'b1, 1'b0} || dut_vec !== exp_vec())
         $display("FAIL mid_reset: got %h expected %h", dut_vec, exp_vec());
      else passed++;
      core_data = w2; core_valid = 1'b1;
      tick();
      core_valid = 1'b0;
      tick();
      total++;
      if ({io_valid, io_data} !== {2'b11, w2[15:0]})
         $display("FAIL mid_restart: got %h expected %h", {io_valid, io_data}, {2'b11, w2[15:0]});
      else passed++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         core_valid = 1'($urandom_range(0, 1));
         core_data  = {$urandom, $urandom};
         token[0]   = ($urandom_range(0, 5) == 0);
         token[1]   = ($urandom_range(0, 5) == 0);
         tick();
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         else passed++;
      end
      core_valid = 1'b0;
      token = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_word();
      test_exhaustion();
      test_asymmetric();
      test_simul_token_fire();
      test_overflow();
      test_reset_mid_word();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
